// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: merges hazard, busy, memory-wait,
// branch and exception requests into per-register hold/bubble vectors and PC redirect.
module pipeline_ctrl #(
    parameter int unsigned RESET_HOLD = 2,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0004
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        id_stall_req_in,
    input  logic        ex_stall_req_in,
    input  logic        mem_stall_req_in,
    input  logic        branch_taken_in,
    input  logic [31:0] branch_target_in,
    input  logic        exception_in,
    output logic [4:0]  stall_out,
    output logic [4:0]  flush_out,
    output logic        pc_redirect_out,
    output logic [31:0] pc_target_out,
    output logic [31:0] stall_count_out
);

    typedef enum logic [1:0] {
        S_HOLD,
        S_RUN,
        S_EXC
    } state_t;

    localparam logic [3:0] HOLD_INIT = 4'(RESET_HOLD - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] hold_cnt;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= S_HOLD;
            hold_cnt <= HOLD_INIT;
        end else begin
            state <= state_nxt;
            if (state == S_HOLD && hold_cnt != 4'd0) begin
                hold_cnt <= hold_cnt - 4'd1;
            end
        end
    end

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        state_nxt       = state;
        stall_out       = 5'b00000;
        flush_out       = 5'b00000;
        pc_redirect_out = 1'b0;
        pc_target_out   = 32'h0000_0000;

        if (reset) begin
            stall_out = 5'b11111;
            flush_out = 5'b11110;
        end else begin
            unique case (state)
                S_HOLD: begin
                    stall_out = 5'b11111;
                    if (hold_cnt == 4'd0) begin
                        state_nxt = S_RUN;
                    end
                end
                S_RUN: begin
                    if (exception_in) begin
                        flush_out       = 5'b11110;
                        pc_redirect_out = 1'b1;
                        pc_target_out   = EXC_VECTOR;
                        state_nxt       = S_EXC;
                    end else if (mem_stall_req_in) begin
                        stall_out = 5'b01111;
                        flush_out = 5'b10000;
                    end else if (ex_stall_req_in) begin
                        stall_out = 5'b00111;
                        flush_out = 5'b01000;
                    end else if (id_stall_req_in) begin
                        stall_out = 5'b00011;
                        flush_out = 5'b00100;
                    end else if (branch_taken_in) begin
                        // Delay slot in IF/ID proceeds, so a taken branch flushes nothing.
                        pc_redirect_out = 1'b1;
                        pc_target_out   = branch_target_in;
                    end
                end
                S_EXC: begin
                    // Squash the wrong-path fetch beat; exception_in is ignored here.
                    flush_out = 5'b00110;
                    state_nxt = S_RUN;
                end
                default: begin
                    state_nxt = S_HOLD;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_count_out <= 32'h0000_0000;
        end else if (state == S_RUN && stall_out[0] && stall_count_out != 32'hFFFF_FFFF) begin
            stall_count_out <= stall_count_out + 32'd1;
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: walks reset hold, stall priorities, branch,
// exception sequencing and counter saturation with hand-computed expectations.
module tb_pipeline_ctrl;

    logic        clock;
    logic        reset;
    logic        id_stall_req_in;
    logic        ex_stall_req_in;
    logic        mem_stall_req_in;
    logic        branch_taken_in;
    logic [31:0] branch_target_in;
    logic        exception_in;
    logic [4:0]  stall_out;
    logic [4:0]  flush_out;
    logic        pc_redirect_out;
    logic [31:0] pc_target_out;
    logic [31:0] stall_count_out;

    int tests_run = 0;
    int tests_failed = 0;

    pipeline_ctrl #(
        .RESET_HOLD(2),
        .EXC_VECTOR(32'h0000_0004)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .id_stall_req_in  (id_stall_req_in),
        .ex_stall_req_in  (ex_stall_req_in),
        .mem_stall_req_in (mem_stall_req_in),
        .branch_taken_in  (branch_taken_in),
        .branch_target_in (branch_target_in),
        .exception_in     (exception_in),
        .stall_out        (stall_out),
        .flush_out        (flush_out),
        .pc_redirect_out  (pc_redirect_out),
        .pc_target_out    (pc_target_out),
        .stall_count_out  (stall_count_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic check_outs(input string tag, input logic [4:0] stall, input logic [4:0] flush,
                              input logic redirect, input logic [31:0] target);
        check({tag, ".stall"},    32'(stall_out),       32'(stall));
        check({tag, ".flush"},    32'(flush_out),       32'(flush));
        check({tag, ".redirect"}, 32'(pc_redirect_out), 32'(redirect));
        check({tag, ".target"},   pc_target_out,        target);
    endtask

    task automatic next_cycle();
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        reset            = 1'b1;
        id_stall_req_in  = 1'b0;
        ex_stall_req_in  = 1'b0;
        mem_stall_req_in = 1'b0;
        branch_taken_in  = 1'b0;
        branch_target_in = 32'h0;
        exception_in     = 1'b0;

        // Reset held for three edges
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_outs("reset", 5'b11111, 5'b11110, 1'b0, 32'h0);
        check("reset.count", stall_count_out, 32'h0);

        // HOLD lasts two edges after release and ignores requests
        reset = 1'b0;
        #1;
        check_outs("hold1", 5'b11111, 5'b00000, 1'b0, 32'h0);
        next_cycle();
        exception_in     = 1'b1;
        branch_taken_in  = 1'b1;
        branch_target_in = 32'h1234_5678;
        #1;
        check_outs("hold2", 5'b11111, 5'b00000, 1'b0, 32'h0);
        exception_in    = 1'b0;
        branch_taken_in = 1'b0;
        next_cycle();
        check_outs("run_idle", 5'b00000, 5'b00000, 1'b0, 32'h0);
        check("run_idle.count", stall_count_out, 32'h0);

        // ID hazard for two cycles
        id_stall_req_in = 1'b1;
        #1;
        check_outs("id1", 5'b00011, 5'b00100, 1'b0, 32'h0);
        next_cycle();
        check_outs("id2", 5'b00011, 5'b00100, 1'b0, 32'h0);
        next_cycle();
        check("id.count", stall_count_out, 32'd2);

        // MEM beats EX beats ID
        mem_stall_req_in = 1'b1;
        ex_stall_req_in  = 1'b1;
        #1;
        check_outs("mem_all", 5'b01111, 5'b10000, 1'b0, 32'h0);
        next_cycle();
        check("mem_all.count", stall_count_out, 32'd3);
        mem_stall_req_in = 1'b0;
        #1;
        check_outs("ex_id", 5'b00111, 5'b01000, 1'b0, 32'h0);
        next_cycle();
        check("ex_id.count", stall_count_out, 32'd4);
        ex_stall_req_in = 1'b0;
        id_stall_req_in = 1'b0;

        // Branch without and with a stall
        branch_taken_in  = 1'b1;
        branch_target_in = 32'h0040_0100;
        #1;
        check_outs("branch", 5'b00000, 5'b00000, 1'b1, 32'h0040_0100);
        ex_stall_req_in = 1'b1;
        #1;
        check_outs("branch_stall", 5'b00111, 5'b01000, 1'b0, 32'h0);
        next_cycle();
        check("branch_stall.count", stall_count_out, 32'd5);
        ex_stall_req_in = 1'b0;
        branch_taken_in = 1'b0;

        // Exception held three cycles alongside a memory stall
        exception_in     = 1'b1;
        mem_stall_req_in = 1'b1;
        #1;
        check_outs("exc1", 5'b00000, 5'b11110, 1'b1, 32'h0000_0004);
        next_cycle();
        check_outs("exc2", 5'b00000, 5'b00110, 1'b0, 32'h0);
        check("exc2.count", stall_count_out, 32'd5);
        next_cycle();
        check_outs("exc3", 5'b00000, 5'b11110, 1'b1, 32'h0000_0004);
        next_cycle();
        exception_in     = 1'b0;
        mem_stall_req_in = 1'b0;
        #1;
        check_outs("exc4", 5'b00000, 5'b00110, 1'b0, 32'h0);
        check("exc.count", stall_count_out, 32'd5);
        next_cycle();
        check_outs("post_exc", 5'b00000, 5'b00000, 1'b0, 32'h0);

        // Preload the counter near saturation
        force dut.stall_count_out = 32'hFFFF_FFFE;
        next_cycle();
        release dut.stall_count_out;
        #1;
        check("preload.count", stall_count_out, 32'hFFFF_FFFE);
        id_stall_req_in = 1'b1;
        next_cycle();
        check("sat1.count", stall_count_out, 32'hFFFF_FFFF);
        next_cycle();
        check("sat2.count", stall_count_out, 32'hFFFF_FFFF);
        next_cycle();
        check("sat3.count", stall_count_out, 32'hFFFF_FFFF);

        // Reset mid-stall
        reset = 1'b1;
        #1;
        check_outs("mid_reset", 5'b11111, 5'b11110, 1'b0, 32'h0);
        check("mid_reset.count", stall_count_out, 32'h0);
        next_cycle();
        reset = 1'b0;
        #1;
        check_outs("mid_reset_hold", 5'b11111, 5'b00000, 1'b0, 32'h0);
        next_cycle();
        check_outs("mid_reset_hold2", 5'b11111, 5'b00000, 1'b0, 32'h0);
        next_cycle();
        check_outs("mid_reset_run", 5'b00011, 5'b00100, 1'b0, 32'h0);
        id_stall_req_in = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no end expected end by 100000");
        $fatal(1, "timeout");
    end

endmodule
